oled_bus_arbiter: RTL and testbench

Shares the write-only parallel OLED bus (CS/E/RW/DC/D[7:0]) between two byte-stream requesters. Port 0 is the power-on init sequencer and port 1 is the runtime pixel/command writer. The block arbitrates round-robin, latches the winning byte and generates bus cycles with parameterised setup, E-high and E-low times. It sits between the requesters and the OLED pins; only this block drives the pins.

---
 rtl/oled_bus_arbiter_if.sv | 39 +++
 rtl/oled_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_oled_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_bus_arbiter_if.sv
// Requester-side and panel-side signals of the OLED bus arbiter, bundled as one interface.
// lock0 exists only when OLED_ARB_LOCK_EN is defined.
interface oled_bus_arbiter_if;
  logic       req0;
  logic       dc0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       dc1;
  logic [7:0] data1;
  logic       ack1;
`ifdef OLED_ARB_LOCK_EN
  logic       lock0;
`endif
  logic       busy;
  logic       oled_cs;
  logic       oled_e;
  logic       oled_rw;
  logic       oled_dc;
  logic [7:0] oled_dout;

  // Requester/testbench side.
  modport master (
    output req0, dc0, data0, req1, dc1, data1,
`ifdef OLED_ARB_LOCK_EN
    output lock0,
`endif
    input  ack0, ack1, busy, oled_cs, oled_e, oled_rw, oled_dc, oled_dout
  );

  // Arbiter side.
  modport slave (
    input  req0, dc0, data0, req1, dc1, data1,
`ifdef OLED_ARB_LOCK_EN
    input  lock0,
`endif
    output ack0, ack1, busy, oled_cs, oled_e, oled_rw, oled_dc, oled_dout
  );
endinterface

// File: rtl/oled_bus_arbiter.sv
// Round-robin arbiter sharing the write-only OLED bus between two byte requesters.
// Define OLED_ARB_LOCK_EN to add lock0 (exclusive ownership for port 0).
module oled_bus_arbiter #(
  parameter int unsigned SETUP  = 1,
  parameter int unsigned E_HIGH = 4,
  parameter int unsigned E_LOW  = 4
) (
  input logic              clk,
  input logic              rst_n,
  oled_bus_arbiter_if.slave bus
);

  localparam int unsigned MaxHe = (E_HIGH > E_LOW) ? E_HIGH : E_LOW;
  localparam int unsigned MaxT  = (SETUP > MaxHe) ? SETUP : MaxHe;
  localparam int unsigned CntW  = $clog2(MaxT) + 1;

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP - 1);
  localparam logic [CntW-1:0] EHighLd = CntW'(E_HIGH - 1);
  localparam logic [CntW-1:0] ELowLd  = CntW'(E_LOW - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StEHi, StELo} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            cs_q, cs_d;
  logic            e_q, e_d;
  logic            dc_q, dc_d;
  logic [7:0]      dout_q, dout_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;

  logic cnt_done;
  logic arb_en;
  logic locked;
  logic grant_valid;
  logic grant_port;
  logic grant_upd;
  logic grant_take;

  assign cnt_done = (cnt_q == '0);
  assign arb_en   = (state_q == StIdle) || ((state_q == StELo) && cnt_done);

`ifdef OLED_ARB_LOCK_EN
  assign locked = bus.lock0;
`else
  assign locked = 1'b0;
`endif

  // Winner selection; while locked, only port 0 may win and the pointer is frozen.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    grant_upd   = 1'b0;
    if (locked) begin
      grant_valid = bus.req0;
    end else if (bus.req0 && bus.req1) begin
      grant_valid = 1'b1;
      grant_port  = ~last_q;
      grant_upd   = 1'b1;
    end else if (bus.req0) begin
      grant_valid = 1'b1;
      grant_upd   = 1'b1;
    end else if (bus.req1) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
      grant_upd   = 1'b1;
    end
  end

  assign grant_take = arb_en && grant_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cs_d    = cs_q;
    e_d     = e_q;
    dc_d    = dc_q;
    dout_d  = dout_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StSetup: begin
        if (cnt_done) begin
          e_d     = 1'b1;
          state_d = StEHi;
          cnt_d   = EHighLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEHi: begin
        if (cnt_done) begin
          e_d     = 1'b0;
          state_d = StELo;
          cnt_d   = ELowLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StELo: begin
        if (cnt_done) begin
          if (!grant_valid) begin
            cs_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A grant overrides the idle/E_LO bookkeeping above; CS stays low on re-grant.
    if (grant_take) begin
      state_d = StSetup;
      cnt_d   = SetupLd;
      cs_d    = 1'b0;
      dc_d    = grant_port ? bus.dc1 : bus.dc0;
      dout_d  = grant_port ? bus.data1 : bus.data0;
      ack0_d  = ~grant_port;
      ack1_d  = grant_port;
      if (grant_upd) begin
        last_d = grant_port;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      cs_q    <= 1'b1;
      e_q     <= 1'b0;
      dc_q    <= 1'b0;
      dout_q  <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      e_q     <= e_d;
      dc_q    <= dc_d;
      dout_q  <= dout_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.oled_cs   = cs_q;
  assign bus.oled_e    = e_q;
  assign bus.oled_rw   = 1'b0;
  assign bus.oled_dc   = dc_q;
  assign bus.oled_dout = dout_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;

endmodule

// File: tb/tb_oled_bus_arbiter.sv
// Self-checking bench for oled_bus_arbiter: directed scenarios plus random traffic against
// a transaction-level model (grant time + offsets). Lock scenarios need OLED_ARB_LOCK_EN.
module tb_oled_bus_arbiter;
  localparam int SETUP  = 1;
  localparam int E_HIGH = 4;
  localparam int E_LOW  = 4;
  localparam int TP     = SETUP + E_HIGH + E_LOW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  oled_bus_arbiter_if bus ();

  oled_bus_arbiter #(
    .SETUP  (SETUP),
    .E_HIGH (E_HIGH),
    .E_LOW  (E_LOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one transfer window of TP cycles starting at the ack cycle m_start.
  bit         m_active;
  int         m_start;
  bit         m_last;
  bit         m_win;
  bit         m_dc;
  logic [7:0] m_dout;

  // Requester state.
  bit         rq[2];
  bit         dcv[2];
  logic [7:0] dat[2];
  bit         granted[2];
  int         gcyc[2];
  bit         lk;

  int ack_cyc[$];
  bit ack_port[$];
  bit ack_dc[$];
  int cnt_cs_lo, cnt_cs_hi, cnt_e_hi;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_start  = 0;
    m_last   = 1'b1;
    m_win    = 1'b0;
    m_dc     = 1'b0;
    m_dout   = 8'h00;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
  endtask

  function automatic logic [14:0] model_out();
    int   p;
    logic e, a0, a1;
    p  = cyc - m_start;
    e  = m_active && (p >= SETUP) && (p < SETUP + E_HIGH);
    a0 = m_active && (p == 0) && !m_win;
    a1 = m_active && (p == 0) && m_win;
    return {!m_active, e, 1'b0, m_dc, m_dout, a0, a1, m_active};
  endfunction

  task automatic apply();
    bus.req0  = rq[0];
    bus.dc0   = dcv[0];
    bus.data0 = dat[0];
    bus.req1  = rq[1];
    bus.dc1   = dcv[1];
    bus.data1 = dat[1];
`ifdef OLED_ARB_LOCK_EN
    bus.lock0 = lk;
`endif
  endtask

  task automatic raise(int p, bit d, logic [7:0] v);
    rq[p]      = 1'b1;
    dcv[p]     = d;
    dat[p]     = v;
    granted[p] = 1'b0;
  endtask

  // One clock: check outputs at negedge, decide the model's next step from the sampled
  // inputs, advance at posedge, return 1 time unit later for new stimulus.
  task automatic tick();
    logic [14:0] exp_v, obs_v;
    bit          arb, locked, grant, port, upd, gdc, fin;
    logic [7:0]  gdata;
    @(negedge clk);
    exp_v = model_out();
    obs_v = {bus.oled_cs, bus.oled_e, bus.oled_rw, bus.oled_dc, bus.oled_dout,
             bus.ack0, bus.ack1, bus.busy};
    check($sformatf("outputs@%0d", cyc), 32'(obs_v), 32'(exp_v));
    if (!bus.oled_cs) cnt_cs_lo++;
    else cnt_cs_hi++;
    if (bus.oled_e) cnt_e_hi++;
    if (bus.ack0 || bus.ack1) begin
      ack_cyc.push_back(cyc);
      ack_port.push_back(bus.ack1);
      ack_dc.push_back(bus.oled_dc);
    end
    grant  = 1'b0;
    port   = 1'b0;
    upd    = 1'b0;
    locked = 1'b0;
    arb    = rst_n && (!m_active || (cyc - m_start == TP - 1));
    if (arb) begin
`ifdef OLED_ARB_LOCK_EN
      locked = bus.lock0;
`endif
      if (locked) begin
        grant = bus.req0;
      end else if (bus.req0 || bus.req1) begin
        grant = 1'b1;
        upd   = 1'b1;
        port  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      end
    end
    gdc   = port ? bus.dc1 : bus.dc0;
    gdata = port ? bus.data1 : bus.data0;
    fin   = arb && m_active && !grant;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (grant) begin
        m_active      = 1'b1;
        m_start       = cyc;
        m_win         = port;
        m_dc          = gdc;
        m_dout        = gdata;
        granted[port] = 1'b1;
        gcyc[port]    = cyc;
        if (upd) m_last = port;
      end else if (fin) begin
        m_active = 1'b0;
      end
    end
    #1;
  endtask

  // Requesters drop req the cycle after their ack unless told to hold.
  task automatic serve(int n, bit hold);
    for (int i = 0; i < n; i++) begin
      tick();
      if (!hold) begin
        for (int p = 0; p < 2; p++) begin
          if (rq[p] && granted[p] && cyc > gcyc[p]) rq[p] = 1'b0;
        end
      end
      apply();
    end
  endtask

  task automatic serve_until_acks(int n, int budget, bit hold);
    for (int i = 0; i < budget && ack_cyc.size() < n; i++) serve(1, hold);
    check("ack_count", ack_cyc.size(), n);
  endtask

  task automatic serve_until_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      serve(1, 1'b0);
      if (!m_active && !rq[0] && !rq[1]) break;
    end
    check("idle_cs", bus.oled_cs, 1);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic clear_log();
    ack_cyc.delete();
    ack_port.delete();
    ack_dc.delete();
  endtask

  task automatic drive_rand();
    for (int p = 0; p < 2; p++) begin
      if (rq[p] && granted[p] && cyc > gcyc[p]) rq[p] = 1'b0;
      if (!rq[p] && $urandom_range(0, 2) != 0) begin
        raise(p, 1'($urandom_range(0, 1)), 8'($urandom));
      end else if (!rq[p]) begin
        dcv[p] = 1'($urandom_range(0, 1));
        dat[p] = 8'($urandom);
      end
    end
`ifdef OLED_ARB_LOCK_EN
    if ($urandom_range(0, 15) == 0) lk = !lk;
`endif
    apply();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rq[0] = 1'b0; rq[1] = 1'b0; dcv[0] = 1'b0; dcv[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00; lk = 1'b0;
    model_reset();
    apply();

    // Reset values are covered by the per-cycle output check.
    serve(2, 1'b1);
    check("rst_rw", bus.oled_rw, 0);

    // Contention from reset: 0,1,0,1,0 with 9-cycle spacing and CS held low.
    rst_n = 1'b1;
    raise(0, 1'b0, 8'h11);
    raise(1, 1'b1, 8'h22);
    apply();
    clear_log();
    for (int i = 0; i < 40 && ack_cyc.size() < 1; i++) serve(1, 1'b1);
    cnt_cs_hi = 0;
    serve_until_acks(5, 60, 1'b1);
    check("cont_cs_gap", cnt_cs_hi, 0);
    if (ack_cyc.size() >= 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cont_port%0d", i), ack_port[i], i % 2);
        check($sformatf("cont_dc%0d", i), ack_dc[i], i % 2);
        check($sformatf("cont_space%0d", i), ack_cyc[i + 1] - ack_cyc[i], TP);
      end
      // Reset during the third E_HI cycle of the fifth (port 0) transfer.
      for (int i = 0; i < 4 && cyc < ack_cyc[4] + SETUP + 2; i++) serve(1, 1'b1);
      check("pre_rst_e", bus.oled_e, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_e", bus.oled_e, 0);
      check("mid_rst_cs", bus.oled_cs, 1);
      check("mid_rst_busy", bus.busy, 0);
      model_reset();
    end

    serve(2, 1'b1);
    rst_n = 1'b1;
    clear_log();
    serve_until_acks(2, 40, 1'b0);
    if (ack_port.size() >= 2) begin
      check("post_rst_first", ack_port[0], 0);
      check("post_rst_second", ack_port[1], 1);
    end

    // Idle gap: CS rises and busy falls, then a new req1 three cycles later.
    serve_until_idle(30);
    serve(3, 1'b0);
    clear_log();
    raise(1, 1'b1, 8'h5A);
    apply();
    c = cyc;
    serve_until_acks(1, 10, 1'b0);
    if (ack_cyc.size() >= 1) begin
      check("gap_latency", ack_cyc[0] - c, 1);
      check("gap_port", ack_port[0], 1);
    end
    serve_until_idle(30);

    // Single byte on port 0.
    clear_log();
    cnt_cs_lo = 0;
    cnt_e_hi  = 0;
    raise(0, 1'b0, 8'hAE);
    apply();
    c = cyc;
    serve(14, 1'b0);
    check("single_ncs", cnt_cs_lo, TP);
    check("single_ne", cnt_e_hi, E_HIGH);
    if (ack_cyc.size() >= 1) begin
      check("single_latency", ack_cyc[0] - c, 1);
      check("single_port", ack_port[0], 0);
      check("single_dc", ack_dc[0], 0);
    end
    check("single_dout", bus.oled_dout, 8'hAE);

`ifdef OLED_ARB_LOCK_EN
    // Locked: four grants all to port 0, then round-robin hands the next one to port 1.
    clear_log();
    lk = 1'b1;
    raise(0, 1'b0, 8'h01);
    raise(1, 1'b1, 8'h02);
    apply();
    serve_until_acks(4, 60, 1'b1);
    for (int i = 0; i < 4 && i < ack_port.size(); i++) check("lock_port", ack_port[i], 0);
    lk = 1'b0;
    apply();
    serve_until_acks(5, 20, 1'b1);
    if (ack_port.size() >= 5) check("unlock_port", ack_port[4], 1);
    rq[0] = 1'b0;
    granted[1] = 1'b0;
    apply();
    serve_until_idle(40);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick();
      drive_rand();
    end
    lk = 1'b0;
    apply();
    serve_until_idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
